// File: rtl/period_meter.sv
// Measures the edge-to-edge half-period of sig_in in t_ms units (C cycles per unit); optional 4-deep averaging under PERIOD_METER_AVG_EN.
// Latency: sig_in change to valid pulse is SYNC_STAGES+2 cycles; t_ms updates in the same cycle as valid.
// Backpressure: none; valid is a 1-cycle pulse and may be high on consecutive cycles.
module period_meter #(
    parameter int CYCLES_PER_UNIT = 25_000,
    parameter int SYNC_STAGES     = 2,
    parameter int TIMEOUT_T_MS    = 2_000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        sig_in,
    output logic [19:0] t_ms,
    output logic        valid,
    output logic        locked,
    output logic        timeout
);

    localparam int CW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [CW-1:0] C_LAST   = CW'(CYCLES_PER_UNIT - 1);
    localparam logic [CW-1:0] ROUND_AT = CW'(CYCLES_PER_UNIT - CYCLES_PER_UNIT / 2);
    localparam logic [19:0]   U_MAX    = 20'hF_FFFF;
    localparam logic [19:0]   TO_UNITS = 20'(TIMEOUT_T_MS);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

    state_t            state_q, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              sig_prev, edge_q;
    logic [CW-1:0]     cyc_q, cyc_nxt, cyc_base;
    logic [19:0]       unit_q, unit_nxt, unit_base;
    logic [19:0]       result, t_new;
    logic              at_limit, meas, restart, lose;

    // Synchroniser plus a registered edge pulse; either polarity counts.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q   <= '0;
            sig_prev <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_prev <= sync_q[SYNC_STAGES-1];
            edge_q   <= sync_q[SYNC_STAGES-1] ^ sig_prev;
        end
    end

    // {unit_q, cyc_q} is the distance of the current cycle from the last edge.
    always_comb begin
        at_limit = (unit_q == TO_UNITS) && (cyc_q == '0);
        if ((cyc_q >= ROUND_AT) && (unit_q != U_MAX))
            result = unit_q + 20'd1;
        else
            result = unit_q;
    end

    always_comb begin
        cyc_base  = restart ? '0 : cyc_q;
        unit_base = restart ? '0 : unit_q;
        if (cyc_base == C_LAST) begin
            cyc_nxt  = '0;
            unit_nxt = (unit_base == U_MAX) ? unit_base : unit_base + 20'd1;
        end else begin
            cyc_nxt  = cyc_base + CW'(1);
            unit_nxt = unit_base;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        meas      = 1'b0;
        restart   = 1'b0;
        lose      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (edge_q) begin
                    state_nxt = S_MEASURE;
                    restart   = 1'b1;
                end
            end
            S_MEASURE: begin
                if (edge_q) begin
                    meas    = 1'b1;
                    restart = 1'b1;
                end else if (at_limit) begin
                    state_nxt = S_TIMEOUT;
                    lose      = 1'b1;
                end
            end
            S_TIMEOUT: begin
                if (edge_q) begin
                    state_nxt = S_MEASURE;
                    restart   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef PERIOD_METER_AVG_EN
    // The live result is the newest of the four; three registers hold the older ones.
    logic [19:0] hist_q [3];
    logic [21:0] sum_rnd;

    always_comb begin
        if (locked)
            sum_rnd = 22'(result) + 22'(hist_q[0]) + 22'(hist_q[1]) + 22'(hist_q[2]) + 22'd2;
        else
            sum_rnd = {result, 2'b00} + 22'd2;
        t_new = 20'(sum_rnd >> 2);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || lose) begin
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
        end else if (meas) begin
            hist_q[0] <= result;
            hist_q[1] <= locked ? hist_q[0] : result;
            hist_q[2] <= locked ? hist_q[1] : result;
        end
    end
`else
    assign t_new = result;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cyc_q   <= '0;
            unit_q  <= '0;
            t_ms    <= '0;
            valid   <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= meas;
            if (restart || state_q == S_MEASURE) begin
                cyc_q  <= cyc_nxt;
                unit_q <= unit_nxt;
            end
            if (meas) begin
                t_ms   <= t_new;
                locked <= 1'b1;
            end
            if (lose) begin
                t_ms    <= '0;
                locked  <= 1'b0;
                timeout <= 1'b1;
            end
            if (restart)
                timeout <= 1'b0;
        end
    end

endmodule
